// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-port synchronous data RAM between three requesters:
// ALU data path (read/write), instruction fetch (read) and VGA framebuffer
// scanner (read). At most one request is granted per cycle. The winner drives
// the RAM port in the same cycle, and the read result comes back one cycle
// later together with a one-cycle valid strobe for the requester that issued
// the read.
//
// Priority is data > fetch > VGA. When MEM_ARB_VGA_GUARD_EN is defined, a
// starvation counter forces VGA to win after VGA_MAX_WAIT consecutive denied
// cycles. When the macro is undefined, priority is strictly fixed and VGA can
// starve indefinitely.
//
// Parameters:
//   ADDR_W        address width
//   DATA_W        data width
//   VGA_MAX_WAIT  denied VGA cycles before VGA is forced to win (1..255)
//
// Ports:
//   clock, reset                      clock and synchronous active-high reset
//   data_req/we/addr/wdata -> gnt     ALU data request and its grant
//   data_rvalid                       rdata holds the data read result
//   fetch_req/addr -> gnt             instruction fetch request and its grant
//   fetch_rvalid                      rdata holds the fetched instruction
//   vga_req/addr -> gnt               framebuffer read request and its grant
//   vga_rvalid                        rdata holds the pixel word
//   rdata                             shared read return (equals mem_rdata)
//   mem_addr/wdata/we, mem_rdata      RAM port
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int VGA_MAX_WAIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Owner of the read whose data arrives on mem_rdata in the next cycle.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_DATA  = 2'd1,
        OWN_FETCH = 2'd2,
        OWN_VGA   = 2'd3
    } owner_t;

    owner_t            r_owner;
    owner_t            w_owner_next;
    logic              w_data_gnt;
    logic              w_fetch_gnt;
    logic              w_vga_gnt;
    logic              w_vga_force;
    logic [ADDR_W-1:0] w_mem_addr;

    // Reject an out-of-range wait limit at elaboration; the counter is 8 bits.
    if ((VGA_MAX_WAIT < 1) || (VGA_MAX_WAIT > 255)) begin : g_bad_max_wait
        $error("mem_port_arbiter: VGA_MAX_WAIT must be within 1..255");
    end

`ifdef MEM_ARB_VGA_GUARD_EN
    logic [7:0] r_vga_wait;
    logic [7:0] w_vga_max;

    assign w_vga_max   = 8'(VGA_MAX_WAIT);
    // A VGA request that has been refused VGA_MAX_WAIT times in a row wins now.
    assign w_vga_force = vga_req & (r_vga_wait == w_vga_max);

    // Starvation counter: counts consecutive denied VGA cycles, saturating.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vga_wait <= 8'd0;
        end else if (!vga_req || w_vga_gnt) begin
            r_vga_wait <= 8'd0;
        end else if (r_vga_wait != w_vga_max) begin
            r_vga_wait <= r_vga_wait + 8'd1;
        end else begin
            r_vga_wait <= r_vga_wait;
        end
    end
`else
    assign w_vga_force = 1'b0;
`endif

    // Grant selection: guard override first, then data > fetch > VGA.
    always_comb begin
        w_data_gnt  = 1'b0;
        w_fetch_gnt = 1'b0;
        w_vga_gnt   = 1'b0;
        if (reset) begin
            w_data_gnt  = 1'b0;
            w_fetch_gnt = 1'b0;
            w_vga_gnt   = 1'b0;
        end else if (w_vga_force) begin
            w_vga_gnt = 1'b1;
        end else if (data_req) begin
            w_data_gnt = 1'b1;
        end else if (fetch_req) begin
            w_fetch_gnt = 1'b1;
        end else if (vga_req) begin
            w_vga_gnt = 1'b1;
        end else begin
            w_vga_gnt = 1'b0;
        end
    end

    // RAM address mux: the winner drives the port, zero when idle.
    always_comb begin
        w_mem_addr = {ADDR_W{1'b0}};
        if (w_data_gnt) begin
            w_mem_addr = data_addr;
        end else if (w_fetch_gnt) begin
            w_mem_addr = fetch_addr;
        end else if (w_vga_gnt) begin
            w_mem_addr = vga_addr;
        end else begin
            w_mem_addr = {ADDR_W{1'b0}};
        end
    end

    // Next read owner: only granted reads are tracked, writes return nothing.
    always_comb begin
        w_owner_next = OWN_NONE;
        if (w_data_gnt && !data_we) begin
            w_owner_next = OWN_DATA;
        end else if (w_fetch_gnt) begin
            w_owner_next = OWN_FETCH;
        end else if (w_vga_gnt) begin
            w_owner_next = OWN_VGA;
        end else begin
            w_owner_next = OWN_NONE;
        end
    end

    // Read owner register; reset drops any in-flight read.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_next;
        end
    end

    assign data_gnt  = w_data_gnt;
    assign fetch_gnt = w_fetch_gnt;
    assign vga_gnt   = w_vga_gnt;

    assign mem_addr  = w_mem_addr;
    assign mem_we    = data_we & w_data_gnt;
    assign mem_wdata = data_wdata;
    assign rdata     = mem_rdata;

    // The owner register still holds a pre-reset read during the first reset
    // cycle, so the strobes are also masked by reset directly.
    assign data_rvalid  = ~reset & (r_owner == OWN_DATA);
    assign fetch_rvalid = ~reset & (r_owner == OWN_FETCH);
    assign vga_rvalid   = ~reset & (r_owner == OWN_VGA);

endmodule
